// File: rtl/reg_queue_pkg.sv
// Shared defaults and helpers for the register-family blocks.
package reg_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_DEPTH = 8;

  // Width of a counter that must represent 0..depth inclusive.
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/reg_queue_if.sv
// Queue-side signal bundle: push/pop/flush controls, data and status.
// ovf/udf exist only when REG_QUEUE_ERR_EN is defined.
interface reg_queue_if import reg_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) ();

  logic                      Load;
  logic                      Pop;
  logic                      Flush;
  logic [WIDTH-1:0]          data_in;
  logic [WIDTH-1:0]          data_out;
  logic                      empty;
  logic                      full;
  logic [cnt_w(DEPTH)-1:0]   count;
`ifdef REG_QUEUE_ERR_EN
  logic                      ovf;
  logic                      udf;
`endif

  modport master (
    output Load, Pop, Flush, data_in,
`ifdef REG_QUEUE_ERR_EN
    input  ovf, udf,
`endif
    input  data_out, empty, full, count
  );

  modport slave (
    input  Load, Pop, Flush, data_in,
`ifdef REG_QUEUE_ERR_EN
    output ovf, udf,
`endif
    output data_out, empty, full, count
  );

endinterface

// File: rtl/reg_queue_reg_n.sv
// WIDTH-bit load-enable register with synchronous active-high reset.
module reg_n #(
  parameter int WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] data_q;

  always_ff @(posedge clk_i) begin
    if (rst_i)     data_q <= '0;
    else if (en_i) data_q <= d_i;
  end

  assign q_o = data_q;

endmodule

// File: rtl/reg_queue.sv
// First-word-fall-through register queue with head/tail pointers.
// Optional sticky overflow/underflow flags under REG_QUEUE_ERR_EN.
module reg_queue import reg_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input logic        Clk,
  input logic        Reset,
  reg_queue_if.slave q
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = cnt_w(DEPTH);

  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             empty, full, push_ok, pop_ok;
  logic [WIDTH-1:0] mem [DEPTH];

  assign empty   = (count_q == '0);
  assign full    = (count_q == CNT_W'(DEPTH));
  // Flush and Reset both discard any push in the same cycle.
  assign push_ok = q.Load && (!full || q.Pop) && !q.Flush && !Reset;
  assign pop_ok  = q.Pop && !empty && !q.Flush && !Reset;

  // Storage is never cleared: pointers and count alone define validity.
  for (genvar i = 0; i < DEPTH; i++) begin : g_entry
    reg_n #(.WIDTH(WIDTH)) u_entry (
      .clk_i (Clk),
      .rst_i (1'b0),
      .en_i  (push_ok && (tail_q == PTR_W'(i))),
      .d_i   (q.data_in),
      .q_o   (mem[i])
    );
  end

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (q.Flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push_ok) tail_d = tail_q + 1'b1;
      if (pop_ok)  head_d = head_q + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

`ifdef REG_QUEUE_ERR_EN
  logic ovf_q, ovf_d, udf_q, udf_d;

  // A combined Load+Pop on an empty queue is a plain push, not an underflow.
  always_comb begin
    ovf_d = ovf_q | (q.Load && full && !q.Pop);
    udf_d = udf_q | (q.Pop && empty && !q.Load);
    if (q.Flush) begin
      ovf_d = 1'b0;
      udf_d = 1'b0;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  end

  assign q.ovf = ovf_q;
  assign q.udf = udf_q;
`endif

  assign q.data_out = empty ? '0 : mem[head_q];
  assign q.empty    = empty;
  assign q.full     = full;
  assign q.count    = count_q;

endmodule
